// File: rtl/triangle_vertex_sequencer_if.sv
// Bundle between the triangle vertex sequencer and its host/rasteriser:
// slot write port, playback control, status and the triangle stream.
interface triangle_vertex_sequencer_if #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 3
);
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [6*COORD_W-1:0]   wr_data;
  logic                   wr_err;
  logic [ADDR_W:0]        num_tri;
  logic                   loop;
  logic                   start;
  logic                   stop;
  logic                   busy;
  logic                   tri_valid;
  logic                   tri_ready;
  logic [ADDR_W-1:0]      tri_idx;
  logic [COORD_W-1:0]     ax;
  logic [COORD_W-1:0]     ay;
  logic [COORD_W-1:0]     bx;
  logic [COORD_W-1:0]     by;
  logic [COORD_W-1:0]     cx;
  logic [COORD_W-1:0]     cy;
  logic                   done;

  // sequencer side: owns the triangle stream and status
  modport master (
    input  wr_en, wr_addr, wr_data, num_tri, loop, start, stop, tri_ready,
    output wr_err, busy, tri_valid, tri_idx, ax, ay, bx, by, cx, cy, done
  );

  // host / rasteriser side
  modport slave (
    output wr_en, wr_addr, wr_data, num_tri, loop, start, stop, tri_ready,
    input  wr_err, busy, tri_valid, tri_idx, ax, ay, bx, by, cx, cy, done
  );
endinterface

// File: rtl/triangle_vertex_sequencer.sv
// Writable triangle vertex store with a sequencer that streams the stored
// triangles in slot order over valid/ready, one-shot or looped.
module triangle_vertex_sequencer #(
  parameter int COORD_W = 10,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479
) (
  input  logic                        clk,
  input  logic                        rst,
  triangle_vertex_sequencer_if.master bus
);

  localparam int DATA_W = 6 * COORD_W;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    FIN     = 2'd3
  } state_t;

  // Vertex pairs are packed {x,y} from the MSB end, so x fields sit at odd
  // COORD_W-sized positions counted from the LSB and y fields at even ones.
  function automatic logic coords_legal(input logic [DATA_W-1:0] d);
    logic               ok;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      x = d[(2*k+1)*COORD_W +: COORD_W];
      y = d[(2*k)*COORD_W +: COORD_W];
      if (32'(x) > 32'(X_MAX)) begin
        ok = 1'b0;
      end else if (32'(y) > 32'(Y_MAX)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  logic [DATA_W-1:0]  mem_r [DEPTH];
  state_t             state_r;
  logic [ADDR_W-1:0]  idx_r;
  logic [CNT_W-1:0]   n_r;
  logic               loop_r;
  logic               busy_r;
  logic               done_r;
  logic               valid_r;
  logic               wr_err_r;
  logic [ADDR_W-1:0]  tri_idx_r;
  logic [DATA_W-1:0]  data_r;

  logic               wr_ok_s;
  logic [CNT_W-1:0]   num_clamped_s;
  logic               last_s;

  // write qualification, playback length clamp and last-slot detect
  always_comb begin
    wr_ok_s       = 1'b0;
    num_clamped_s = bus.num_tri;
    last_s        = 1'b0;
    if (bus.wr_en && (32'(bus.wr_addr) < 32'(DEPTH))) begin
      wr_ok_s = coords_legal(bus.wr_data);
    end else begin
      wr_ok_s = 1'b0;
    end
    if (32'(bus.num_tri) > 32'(DEPTH)) begin
      num_clamped_s = CNT_W'(DEPTH);
    end else begin
      num_clamped_s = bus.num_tri;
    end
    if ({1'b0, idx_r} == (n_r - CNT_W'(1))) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // vertex store: no reset so contents survive rst; read-first on collision
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // one-cycle rejection flag for the previous cycle's write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= bus.wr_en & ~wr_ok_s;
    end
  end

  // playback sequencer with registered stream and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      n_r       <= '0;
      loop_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      valid_r   <= 1'b0;
      tri_idx_r <= '0;
      data_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            n_r    <= num_clamped_s;
            loop_r <= bus.loop;
            idx_r  <= '0;
            busy_r <= 1'b1;
            if (num_clamped_s == CNT_W'(0)) begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end else begin
              state_r <= FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.stop) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
          end else begin
            data_r    <= mem_r[idx_r];
            tri_idx_r <= idx_r;
            valid_r   <= 1'b1;
            state_r   <= PRESENT;
          end
        end
        PRESENT: begin
          // stop outranks the handshake; an accepted triangle is simply dropped
          if (bus.stop) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
          end else if (bus.tri_ready) begin
            valid_r <= 1'b0;
            if (!last_s) begin
              idx_r   <= idx_r + ADDR_W'(1);
              state_r <= FETCH;
            end else if (loop_r) begin
              idx_r   <= '0;
              state_r <= FETCH;
            end else begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_err    = wr_err_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.tri_valid = valid_r;
  assign bus.tri_idx   = tri_idx_r;
  assign bus.ax        = data_r[5*COORD_W +: COORD_W];
  assign bus.ay        = data_r[4*COORD_W +: COORD_W];
  assign bus.bx        = data_r[3*COORD_W +: COORD_W];
  assign bus.by        = data_r[2*COORD_W +: COORD_W];
  assign bus.cx        = data_r[1*COORD_W +: COORD_W];
  assign bus.cy        = data_r[0*COORD_W +: COORD_W];

endmodule

// File: tb/tb_triangle_vertex_sequencer.sv
// Scoreboard bench: stimulus queues expected triangles/pulses with their
// cycle numbers, a negedge monitor compares whatever the DUT presents.
module tb_triangle_vertex_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  triangle_vertex_sequencer_if #(.COORD_W(10), .ADDR_W(3)) bus ();

  triangle_vertex_sequencer #(
    .COORD_W(10), .DEPTH(8), .ADDR_W(3), .X_MAX(639), .Y_MAX(479)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [59:0] data;
    int          vcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          done_q[$];
  int          err_q[$];
  logic [59:0] ref_mem [8];
  int          vstart = -1;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [59:0] pack(input int ax, input int ay, input int bx,
                                       input int by, input int cx, input int cy);
    return {10'(ax), 10'(ay), 10'(bx), 10'(by), 10'(cx), 10'(cy)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int addr, input logic [59:0] d, input bit expect_err);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_data = d;
    if (expect_err) err_q.push_back(cyc + 1);
    else ref_mem[addr] = d;
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic push_exp(input int idx, input int vcyc);
    exp_t e;
    e.idx  = 3'(idx);
    e.data = ref_mem[idx];
    e.vcyc = vcyc;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.tri_valid, bus.busy, bus.done, bus.wr_err, bus.tri_idx}), 64'd0);
    check({tag, "_data"}, 64'({bus.ax, bus.ay, bus.bx, bus.by, bus.cx, bus.cy}), 64'd0);
  endtask

  // monitor: stream, done and wr_err checked against the queued expectations
  always @(negedge clk) begin
    exp_t e;
    if (bus.tri_valid === 1'b1) begin
      if (prev_valid !== 1'b1) vstart = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(bus.tri_idx), 64'hffff);
      end else begin
        e = exp_q[0];
        check("tri_idx", 64'(bus.tri_idx), 64'(e.idx));
        check("tri_data", 64'({bus.ax, bus.ay, bus.bx, bus.by, bus.cx, bus.cy}), 64'(e.data));
        if (bus.tri_ready === 1'b1) begin
          if (e.vcyc >= 0) check("valid_cycle", 64'(vstart), 64'(e.vcyc));
          void'(exp_q.pop_front());
        end
      end
    end
    prev_valid = bus.tri_valid;
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) check("unexpected_done", 64'(cyc), 64'hffff);
      else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
    end
    if (bus.wr_err === 1'b1) begin
      if (err_q.size() == 0) check("unexpected_wr_err", 64'(cyc), 64'hffff);
      else check("wr_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
    end
  end

  initial begin
    #100000;
    mismatched++;
    $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int t;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.num_tri = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.tri_ready = 1'b0;

    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(1);

    // slot 1 and slot 2 both carry a y above 479, and slot 3 first gets x=640
    write_slot(0, pack(30, 180, 510, 150, 120, 420), 1'b0);
    write_slot(1, pack(300, 360, 540, 390, 390, 540), 1'b1);
    write_slot(2, pack(150, 480, 270, 570, 120, 630), 1'b1);
    write_slot(3, pack(640, 0, 0, 0, 0, 0), 1'b1);
    write_slot(3, pack(639, 479, 0, 0, 639, 479), 1'b0);
    write_slot(1, pack(300, 360, 540, 390, 390, 470), 1'b0);
    tick(2);

    // two triangles one-shot, consumer always ready
    bus.tri_ready = 1'b1; bus.num_tri = 4'd2; bus.loop = 1'b0; bus.start = 1'b1;
    t = cyc;
    push_exp(0, t + 2); push_exp(1, t + 4); done_q.push_back(t + 5);
    tick(1); bus.start = 1'b0;
    tick(4);
    check("busy_in_fin", 64'(bus.busy), 64'd1);
    tick(1);
    check("busy_after_fin", 64'(bus.busy), 64'd0);
    tick(2);

    // consumer stalls five cycles on slot 0
    bus.tri_ready = 1'b0; bus.num_tri = 4'd1; bus.start = 1'b1;
    t = cyc;
    push_exp(0, t + 2); done_q.push_back(t + 8);
    tick(1); bus.start = 1'b0;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      check("valid_held", 64'(bus.tri_valid), 64'd1);
      tick(1);
    end
    bus.tri_ready = 1'b1;
    tick(3);

    // zero-length playback
    bus.num_tri = 4'd0; bus.start = 1'b1;
    t = cyc;
    done_q.push_back(t + 1);
    tick(1); bus.start = 1'b0;
    check("busy_zero_len", 64'(bus.busy), 64'd1);
    tick(1);
    check("idle_zero_len", 64'(bus.busy), 64'd0);
    tick(1);

    // fill remaining slots, then ask for 12 -> clamps to 8
    write_slot(2, pack(150, 400, 270, 470, 120, 430), 1'b0);
    write_slot(4, pack(1, 2, 3, 4, 5, 6), 1'b0);
    write_slot(5, pack(100, 200, 300, 400, 500, 100), 1'b0);
    write_slot(6, pack(638, 478, 10, 20, 30, 40), 1'b0);
    write_slot(7, pack(7, 8, 9, 10, 11, 12), 1'b0);
    tick(1);
    bus.num_tri = 4'd12; bus.start = 1'b1;
    t = cyc;
    for (int k = 0; k < 8; k++) push_exp(k, t + 2 + 2 * k);
    done_q.push_back(t + 17);
    tick(1); bus.start = 1'b0;
    tick(17);
    check("busy_after_clamped", 64'(bus.busy), 64'd0);
    tick(1);

    // looped playback stopped while fetching the fifth triangle
    bus.num_tri = 4'd2; bus.loop = 1'b1; bus.start = 1'b1;
    t = cyc;
    push_exp(0, t + 2); push_exp(1, t + 4); push_exp(0, t + 6); push_exp(1, t + 8);
    tick(1); bus.start = 1'b0; bus.loop = 1'b0;
    tick(8);
    bus.stop = 1'b1;
    tick(1); bus.stop = 1'b0;
    check("busy_after_stop", 64'(bus.busy), 64'd0);
    check("valid_after_stop", 64'(bus.tri_valid), 64'd0);
    tick(4);

    // start and stop together in IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    tick(1); bus.start = 1'b0; bus.stop = 1'b0;
    check("busy_start_stop", 64'(bus.busy), 64'd0);
    tick(3);

    // reset while presenting, then replay to show memory survived
    bus.tri_ready = 1'b0; bus.num_tri = 4'd2; bus.start = 1'b1;
    t = cyc;
    push_exp(0, t + 2);
    tick(1); bus.start = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    rst = 1'b0;
    check_outputs_zero("mid_reset");
    tick(1);
    bus.tri_ready = 1'b1; bus.start = 1'b1;
    t = cyc;
    push_exp(0, t + 2); push_exp(1, t + 4); done_q.push_back(t + 5);
    tick(1); bus.start = 1'b0;
    tick(8);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);
    check("err_q_drained", 64'(err_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
